// File: rtl/video_dither.sv
`default_nettype none
// ============================================================================
// Module   : video_dither
// Brief    : Pixel-rate 4x4 ordered dither with requantisation to OUT_BITS
//            and MSB-replication back to 8 bits per channel. One ce_pix of
//            latency. The optional temporal pattern rotation is enabled with
//            the VIDEO_DITHER_TEMPORAL_EN macro.
// Revision : 1.0 - initial release
// ============================================================================
module video_dither #(
    parameter int OUT_BITS = 6
) (
    input  logic        clk_vid,
    input  logic        reset_n,
    input  logic        ce_pix,
    input  logic        dither_en,
    input  logic        HSync,
    input  logic        VSync,
    input  logic        HBlank,
    input  logic        VBlank,
    input  logic        DE,
    input  logic [23:0] RGB_in,
    output logic        HSync_out,
    output logic        VSync_out,
    output logic        HBlank_out,
    output logic        VBlank_out,
    output logic        DE_out,
    output logic [23:0] RGB_out
);

    localparam int c_D = 8 - OUT_BITS;

    logic [1:0]  r_x_cnt;
    logic [1:0]  r_y_cnt;
    logic        r_de_d;
    logic        r_vs_d;
    logic        w_de_fall;
    logic        w_vs_rise;
    logic [1:0]  w_x_idx;
    logic [1:0]  w_y_idx;
    logic [3:0]  w_bayer;
    logic [3:0]  w_t;
    logic [23:0] w_rgb_dith;
    logic [23:0] w_rgb_next;

    assign w_de_fall = r_de_d & ~DE;
    assign w_vs_rise = VSync & ~r_vs_d;

`ifdef VIDEO_DITHER_TEMPORAL_EN
    logic [1:0] r_frame;

    always_ff @(posedge clk_vid or negedge reset_n) begin
        if (!reset_n) begin
            r_frame <= 2'd0;
        end else if (ce_pix && w_vs_rise) begin
            r_frame <= r_frame + 2'd1;
        end
    end

    // Swapping the frame bits for the row index walks the pattern diagonally.
    assign w_x_idx = r_x_cnt ^ r_frame;
    assign w_y_idx = r_y_cnt ^ {r_frame[0], r_frame[1]};
`else
    assign w_x_idx = r_x_cnt;
    assign w_y_idx = r_y_cnt;
`endif

    always_comb begin
        w_bayer = 4'd0;
        case ({w_y_idx, w_x_idx})
            4'b00_00: w_bayer = 4'd0;
            4'b00_01: w_bayer = 4'd8;
            4'b00_10: w_bayer = 4'd2;
            4'b00_11: w_bayer = 4'd10;
            4'b01_00: w_bayer = 4'd12;
            4'b01_01: w_bayer = 4'd4;
            4'b01_10: w_bayer = 4'd14;
            4'b01_11: w_bayer = 4'd6;
            4'b10_00: w_bayer = 4'd3;
            4'b10_01: w_bayer = 4'd11;
            4'b10_10: w_bayer = 4'd1;
            4'b10_11: w_bayer = 4'd9;
            4'b11_00: w_bayer = 4'd15;
            4'b11_01: w_bayer = 4'd7;
            4'b11_10: w_bayer = 4'd13;
            4'b11_11: w_bayer = 4'd5;
            default:  w_bayer = 4'd0;
        endcase
    end

    assign w_t = w_bayer >> (4 - c_D);

    // Saturating add, truncate to OUT_BITS, then replicate MSBs into the
    // dropped LSBs so that full scale maps back to 0xFF.
    function automatic logic [7:0] quantise(input logic [7:0] chan, input logic [3:0] thr);
        logic [8:0]          sum;
        logic [7:0]          sat;
        logic [OUT_BITS-1:0] q;
        sum = {1'b0, chan} + {5'd0, thr};
        sat = sum[8] ? 8'hFF : sum[7:0];
        q   = sat[7:c_D];
        return {q, q[OUT_BITS-1 -: c_D]};
    endfunction

    for (genvar i = 0; i < 3; i++) begin : g_chan
        assign w_rgb_dith[8*i +: 8] = quantise(RGB_in[8*i +: 8], w_t);
    end

    assign w_rgb_next = (dither_en && DE) ? w_rgb_dith : RGB_in;

    always_ff @(posedge clk_vid or negedge reset_n) begin
        if (!reset_n) begin
            r_x_cnt    <= 2'd0;
            r_y_cnt    <= 2'd0;
            r_de_d     <= 1'b0;
            r_vs_d     <= 1'b0;
            HSync_out  <= 1'b0;
            VSync_out  <= 1'b0;
            HBlank_out <= 1'b0;
            VBlank_out <= 1'b0;
            DE_out     <= 1'b0;
            RGB_out    <= 24'd0;
        end else if (ce_pix) begin
            r_de_d     <= DE;
            r_vs_d     <= VSync;
            r_x_cnt    <= DE ? r_x_cnt + 2'd1 : 2'd0;
            // A frame start overrides the end-of-line row advance.
            if (w_vs_rise) begin
                r_y_cnt <= 2'd0;
            end else if (w_de_fall) begin
                r_y_cnt <= r_y_cnt + 2'd1;
            end
            HSync_out  <= HSync;
            VSync_out  <= VSync;
            HBlank_out <= HBlank;
            VBlank_out <= VBlank;
            DE_out     <= DE;
            RGB_out    <= w_rgb_next;
        end
    end

endmodule
`default_nettype wire
